mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single memory-controller port between icache (fetch misses) and dcache (MSHR issue).
//  Grants one requester per cycle combinationally, since caches see the accept response in the issue cycle.
//  Records which requester owns each outstanding memory tag; routes tag/data returns only to that owner.
//  Sits between the two caches and mem_controller.
// PARAMETERS
//  STARVE_LIMIT   4   consecutive denied icache-request cycles before icache wins over dcache
//  NUM_TAGS       16  memory tag space; tag 0 is reserved as "none"
// PORTS
//  clock                 in   1     system clock
//  reset                 in   1     synchronous, active-high
//  icache2arb_command    in   2     BUS_NONE/BUS_LOAD
//  icache2arb_addr       in   XLEN  fetch address, 8-byte aligned
//  dcache2arb_command    in   2     BUS_NONE/BUS_LOAD/BUS_STORE
//  dcache2arb_addr       in   XLEN  block address
//  dcache2arb_data       in   64    store data
//  arb2mem_command       out  2     command to mem_controller
//  arb2mem_addr          out  XLEN
//  arb2mem_data          out  64
//  mem2arb_response      in   4     accept tag, 0 = rejected
//  mem2arb_data          in   64
//  mem2arb_tag           in   4     completing tag, 0 = none
//  arb2icache_response   out  4     mem2arb_response if icache granted, else 0
//  arb2icache_data       out  64
//  arb2icache_tag        out  4     mem2arb_tag if owner == ICACHE, else 0
//  arb2dcache_response   out  4     same rules for dcache
//  arb2dcache_data       out  64
//  arb2dcache_tag        out  4
//  outstanding_cnt       out  5     number of valid tag-table entries
//  orphan_tag_err        out  1     sticky: a nonzero tag returned with no valid owner
// BEHAVIOUR
//  - Reset: starve_cnt=0, all table entries invalid, outstanding_cnt=0, orphan_tag_err=0.
//    While reset is high, arb2mem_command=BUS_NONE and addr/data=0.
//    All response/tag outputs are 0; all data outputs are 0.
//  - Grant (combinational). Only dcache requests -> DCACHE. Only icache requests -> ICACHE.
//    Both request -> ICACHE if starve_cnt>=STARVE_LIMIT, else DCACHE. Neither -> NONE, outputs 0.
//  - Granted requester's command/addr/data drive arb2mem_*. Icache data drives 0.
//  - Response routing: mem2arb_response is forwarded only to the granted requester; the other sees 0.
//    Nonzero response = accepted.
//  - starve_cnt:
//    icache requests and is not accepted (not granted, or response 0) -> increment, saturating at STARVE_LIMIT.
//    icache accepted -> clear. icache idle -> clear.
//  - Tag table, NUM_TAGS x {valid, owner}:
//    accept (response!=0) -> entry[response] <= {1, granted}, registered next edge.
//    Return (tag!=0, entry valid) -> data and tag routed same cycle to owner; entry cleared next edge.
//    Applies to both loads and stores.
//  - Data outputs carry mem2arb_data only to the tag owner, else 0.
//  - Simultaneous accept and return of the same tag in one cycle: route the return to the old owner,
//    then the entry ends valid with the new owner.
//  - Return of tag with invalid entry: routed to nobody; orphan_tag_err <= 1 (sticky until reset).
//  - Accept of a tag whose entry is still valid: overwrite the entry. No error.
//  - outstanding_cnt is registered = popcount(valid), range 0..15.
//  - Reset mid-operation clears the table; returns arriving after reset for pre-reset tags set orphan_tag_err.
// STRUCTURE
//  - Shared sys_defs package: BUS_COMMAND (existing), new MEM_REQ_OWNER enum {OWNER_ICACHE, OWNER_DCACHE},
//    and a MEM_TAG_OWNER_ENTRY struct {valid, owner}.
//  - Sub-module mem_tag_owner_table holds the table: alloc port, lookup/clear port, popcount, orphan flag.
//  - The top level holds grant logic and the starvation counter.
// TESTING
//  1. Reset, then dcache LOAD 0x100 with response=3 -> arb2dcache_response=3, arb2icache_response=0.
//     Later tag=3, data=0xDEAD -> dcache gets tag 3/data; icache tag 0. outstanding 1->0.
//  2. Both request every cycle, mem accepts every cycle with tags 1..
//     -> dcache granted 4 cycles, icache granted on the 5th (starve_cnt=4), then counter resets.
//  3. icache LOAD accepted with tag 5, dcache STORE accepted with tag 6.
//     Return tag 6 -> routed to dcache; return tag 5 -> routed to icache.
//  4. Same cycle: tag=7 returns (owner icache) and dcache is accepted with response=7
//     -> icache gets the return; next cycle entry 7 is owned by dcache.
//  5. Return tag=9 with no outstanding entry -> both caches see tag 0, orphan_tag_err=1 and it stays 1.
//  6. Three accepts outstanding, assert reset one cycle -> outstanding_cnt=0, arb2mem_command=BUS_NONE
//     during reset, orphan_tag_err=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: bus commands, requester
// ownership and the tag-owner table entry.
package mem_arbiter_pkg;

  localparam int XLEN  = 64;
  localparam int TAG_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } MEM_REQ_OWNER;

  typedef struct packed {
    logic         valid;
    MEM_REQ_OWNER owner;
  } MEM_TAG_OWNER_ENTRY;

  typedef enum logic [1:0] {
    GRANT_NONE   = 2'h0,
    GRANT_ICACHE = 2'h1,
    GRANT_DCACHE = 2'h2
  } GRANT_SEL;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Tag-owner table: remembers which cache owns each outstanding memory tag,
// answers same-cycle lookups for returning tags, counts valid entries and
// flags returns that match no outstanding request.
import mem_arbiter_pkg::*;

module mem_tag_owner_table #(
  parameter int NUM_TAGS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  logic             alloc_owner_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             lookup_valid_o,
  output logic             lookup_owner_o,
  output logic [CNT_W-1:0] outstanding_cnt_o
  ,
  output logic             orphan_tag_err_o
);

  MEM_TAG_OWNER_ENTRY entry_q [NUM_TAGS];
  MEM_TAG_OWNER_ENTRY entry_d [NUM_TAGS];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               orphan_q, orphan_d;
  logic               lookup_hit;

  // Tag 0 means "no tag" and never reports a valid owner.
  assign lookup_hit        = (lookup_tag_i != '0) && entry_q[lookup_tag_i].valid;
  assign lookup_valid_o    = lookup_hit;
  assign lookup_owner_o    = entry_q[lookup_tag_i].owner;
  assign outstanding_cnt_o = cnt_q;
  assign orphan_tag_err_o  = orphan_q;

  // Next table state: retire the returning tag first, then let a same-cycle
  // accept of that tag claim the entry for its new owner.
  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (lookup_hit) begin
      entry_d[lookup_tag_i].valid = 1'b0;
    end
    if (alloc_en_i) begin
      entry_d[alloc_tag_i].valid = 1'b1;
      entry_d[alloc_tag_i].owner = MEM_REQ_OWNER'(alloc_owner_i);
    end
    orphan_d = orphan_q | ((lookup_tag_i != '0) && !lookup_hit);
    cnt_d = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      cnt_d = cnt_d + CNT_W'(entry_d[i].valid);
    end
  end

  // Table, occupancy count and sticky orphan flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        entry_q[i] <= '{valid: 1'b0, owner: OWNER_ICACHE};
      end
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        entry_q[i] <= entry_d[i];
      end
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory-port arbiter between icache fetch misses and dcache MSHR issue.
// The grant is combinational so the accept response reaches the winning
// cache in its issue cycle; returns are steered to the tag's recorded owner.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       icache2arb_command,
  input  logic [XLEN-1:0]  icache2arb_addr,
  input  logic [1:0]       dcache2arb_command,
  input  logic [XLEN-1:0]  dcache2arb_addr,
  input  logic [63:0]      dcache2arb_data,
  output logic [1:0]       arb2mem_command,
  output logic [XLEN-1:0]  arb2mem_addr,
  output logic [63:0]      arb2mem_data,
  input  logic [3:0]       mem2arb_response,
  input  logic [63:0]      mem2arb_data,
  input  logic [3:0]       mem2arb_tag,
  output logic [3:0]       arb2icache_response,
  output logic [63:0]      arb2icache_data,
  output logic [3:0]       arb2icache_tag,
  output logic [3:0]       arb2dcache_response,
  output logic [63:0]      arb2dcache_data,
  output logic [3:0]       arb2dcache_tag,
  output logic [4:0]       outstanding_cnt,
  output logic             orphan_tag_err
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  GRANT_SEL            grant;
  logic                icache_req, dcache_req;
  logic                icache_starved, icache_accepted, accept;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                ret_valid, ret_owner_raw, ret_hit;
  MEM_REQ_OWNER        ret_owner;

  assign icache_req      = (icache2arb_command != BUS_NONE);
  assign dcache_req      = (dcache2arb_command != BUS_NONE);
  assign icache_starved  = (starve_q >= STARVE_W'(STARVE_LIMIT));
  assign accept          = (grant != GRANT_NONE) && (mem2arb_response != '0);
  assign icache_accepted = (grant == GRANT_ICACHE) && accept;
  assign ret_owner       = MEM_REQ_OWNER'(ret_owner_raw);
  assign ret_hit         = !reset && ret_valid;

  // Pick the requester: dcache wins ties unless icache has been starved.
  always_comb begin
    grant = GRANT_NONE;
    if (!reset) begin
      if (icache_req && dcache_req) begin
        grant = icache_starved ? GRANT_ICACHE : GRANT_DCACHE;
      end else if (icache_req) begin
        grant = GRANT_ICACHE;
      end else if (dcache_req) begin
        grant = GRANT_DCACHE;
      end
    end
  end

  // Drive the memory port from the winner and hand it the accept response.
  always_comb begin
    arb2mem_command     = BUS_NONE;
    arb2mem_addr        = '0;
    arb2mem_data        = '0;
    arb2icache_response = '0;
    arb2dcache_response = '0;
    case (grant)
      GRANT_ICACHE: begin
        arb2mem_command     = icache2arb_command;
        arb2mem_addr        = icache2arb_addr;
        arb2icache_response = mem2arb_response;
      end
      GRANT_DCACHE: begin
        arb2mem_command     = dcache2arb_command;
        arb2mem_addr        = dcache2arb_addr;
        arb2mem_data        = dcache2arb_data;
        arb2dcache_response = mem2arb_response;
      end
      default: ;
    endcase
  end

  // Steer a returning tag and its data to the cache that owns the tag.
  always_comb begin
    arb2icache_tag  = '0;
    arb2icache_data = '0;
    arb2dcache_tag  = '0;
    arb2dcache_data = '0;
    if (ret_hit) begin
      if (ret_owner == OWNER_ICACHE) begin
        arb2icache_tag  = mem2arb_tag;
        arb2icache_data = mem2arb_data;
      end else begin
        arb2dcache_tag  = mem2arb_tag;
        arb2dcache_data = mem2arb_data;
      end
    end
  end

  // Count consecutive cycles icache asked but was not accepted, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!icache_req || icache_accepted) begin
      starve_d = '0;
    end else if (!icache_starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  mem_tag_owner_table #(
    .NUM_TAGS(NUM_TAGS)
  ) u_tag_table (
    .clock             (clock),
    .reset             (reset),
    .alloc_en_i        (accept),
    .alloc_tag_i       (mem2arb_response),
    .alloc_owner_i     (grant == GRANT_DCACHE),
    .lookup_tag_i      (mem2arb_tag),
    .lookup_valid_o    (ret_valid),
    .lookup_owner_o    (ret_owner_raw),
    .outstanding_cnt_o (outstanding_cnt),
    .orphan_tag_err_o  (orphan_tag_err)
  );

endmodule
